// File: rtl/button_debounce.sv
// Four-channel push-button synchroniser and debouncer with per-channel press pulses.
// Optional feature macro: BTN_ACTIVE_LOW_EN (invert raw pads for pull-up buttons).
//
// state  | meaning
// -------+-----------------------------------------------
// REL    | stable released, btn_level=0
// P_WAIT | candidate press, counting stable high samples
// PRS    | stable pressed, btn_level=1
// R_WAIT | candidate release, counting stable low samples
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] button,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic       press_any,
  output logic [1:0] press_idx
);

  typedef enum logic [1:0] {
    REL    = 2'd0,
    P_WAIT = 2'd1,
    PRS    = 2'd2,
    R_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [3:0]       pad;
  logic [3:0]       s1;
  logic [3:0]       s2;
  state_t           state     [4];
  state_t           state_nxt [4];
  logic [CNT_W-1:0] cnt       [4];
  logic [CNT_W-1:0] cnt_nxt   [4];
  logic [3:0]       level_nxt;
  logic [3:0]       press_nxt;

`ifdef BTN_ACTIVE_LOW_EN
  // Pull-up pads read 0 when pressed; the flops still hold logical "pressed".
  assign pad = ~button;
`else
  assign pad = button;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      btn_level <= '0;
      btn_press <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i] <= REL;
        cnt[i]   <= '0;
      end
    end else begin
      s1        <= pad;
      s2        <= s1;
      btn_level <= level_nxt;
      btn_press <= press_nxt;
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    level_nxt = '0;
    press_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        REL: begin
          if (s2[i]) begin
            state_nxt[i] = P_WAIT;
            cnt_nxt[i]   = '0;
          end
        end
        P_WAIT: begin
          if (!s2[i]) begin
            state_nxt[i] = REL;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == TC) begin
            state_nxt[i] = PRS;
            cnt_nxt[i]   = '0;
            press_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + 1'b1;
          end
        end
        PRS: begin
          if (!s2[i]) begin
            state_nxt[i] = R_WAIT;
            cnt_nxt[i]   = '0;
          end
        end
        R_WAIT: begin
          if (s2[i]) begin
            state_nxt[i] = PRS;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == TC) begin
            state_nxt[i] = REL;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + 1'b1;
          end
        end
        default: begin
          state_nxt[i] = REL;
          cnt_nxt[i]   = '0;
        end
      endcase
      level_nxt[i] = (state_nxt[i] == PRS) || (state_nxt[i] == R_WAIT);
    end
  end

  assign press_any = |btn_press;

  // Channel 0 wins when several pulse together.
  always_comb begin
    press_idx = 2'd0;
    if (btn_press[0])      press_idx = 2'd0;
    else if (btn_press[1]) press_idx = 2'd1;
    else if (btn_press[2]) press_idx = 2'd2;
    else if (btn_press[3]) press_idx = 2'd3;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random bounce traffic,
// checked every cycle against a run-length reference model.
module tb_button_debounce;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] button = 4'b0000;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic       press_any;
  logic [1:0] press_idx;

  int checks = 0;
  int errors = 0;

  button_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .button    (button),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .press_any (press_any),
    .press_idx (press_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a channel flips its level once the synchronised input has
  // disagreed with it on D consecutive edges; a flip to 1 emits one pulse.
  logic [3:0] m_s1, m_s2, m_level, m_press, m_pad;
  int         run [4];
  bit         m_valid = 0;

  always @(posedge clk) begin
`ifdef BTN_ACTIVE_LOW_EN
    m_pad = ~button;
`else
    m_pad = button;
`endif
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      m_valid = 1;
    end else begin
      m_press = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_level[i]) begin
          run[i]++;
          if (run[i] == D) begin
            m_level[i] = m_s2[i];
            m_press[i] = m_s2[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = m_pad;
    end
  end

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_level", 32'(btn_level), 32'(m_level));
      check("model_press", 32'(btn_press), 32'(m_press));
      check("model_any", 32'(press_any), 32'(|m_press));
      check("model_idx", 32'(press_idx), 32'(low_idx(m_press)));
    end
  end

  // Counts negedges until any press pulse appears; 99 if none within budget.
  task automatic wait_press(output int n);
    n = 99;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (btn_press != 4'b0000) begin
        n = k;
        return;
      end
    end
  endtask

  task automatic wait_release2(output int n);
    n = 99;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!btn_level[2]) begin
        n = k;
        return;
      end
    end
  endtask

  int n;

  initial begin
    // Reset held with all buttons pressed.
    @(negedge clk);
    button = 4'b1111;
    reset  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_level", 32'(btn_level), 32'h0);
      check("rst_press", 32'(btn_press), 32'h0);
      check("rst_any", 32'(press_any), 32'h0);
      check("rst_idx", 32'(press_idx), 32'h0);
    end
    reset = 1'b0;
    wait_press(n);
    check("held_lat", 32'(n), 32'd6);
    check("held_press", 32'(btn_press), 32'hf);
    check("held_level", 32'(btn_level), 32'hf);
    check("held_idx", 32'(press_idx), 32'd0);
    @(negedge clk);
    check("held_once", 32'(btn_press), 32'h0);
    button = 4'b0000;
    repeat (8) @(negedge clk);
    check("all_rel", 32'(btn_level), 32'h0);

    // Single channel press and release.
    button = 4'b0100;
    wait_press(n);
    check("b2_lat", 32'(n), 32'd6);
    check("b2_press", 32'(btn_press), 32'h4);
    check("b2_idx", 32'(press_idx), 32'd2);
    @(negedge clk);
    check("b2_once", 32'(btn_press), 32'h0);
    check("b2_level", 32'(btn_level), 32'h4);
    button = 4'b0000;
    wait_release2(n);
    check("b2_rel_lat", 32'(n), 32'd6);
    repeat (4) @(negedge clk);

    // Bounce on channel 1 shorter than the debounce window.
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < 4; p++) begin
        button = (p < 3) ? 4'b0010 : 4'b0000;
        @(negedge clk);
        check("bounce_press", 32'(btn_press), 32'h0);
        check("bounce_level", 32'(btn_level[1]), 32'h0);
      end
    end
    button = 4'b0000;
    repeat (8) @(negedge clk);

    // Simultaneous press on channels 3 and 1.
    button = 4'b1010;
    wait_press(n);
    check("sim_lat", 32'(n), 32'd6);
    check("sim_press", 32'(btn_press), 32'ha);
    check("sim_idx", 32'(press_idx), 32'd1);
    check("sim_any", 32'(press_any), 32'd1);
    button = 4'b0000;
    repeat (8) @(negedge clk);

    // Reset while channel 0 is mid-count; the pulse must restart from scratch.
    button = 4'b0001;
    repeat (5) @(negedge clk);
    check("mid_nopulse", 32'(btn_press), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_press(n);
    check("mid_lat", 32'(n), 32'd6);
    check("mid_press", 32'(btn_press), 32'h1);
    button = 4'b0000;
    repeat (8) @(negedge clk);

    // Random bouncing traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) button[i] = ~button[i];
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Four-channel push-button conditioner that sits directly upstream of the mole display/scoring logic. It synchronises the raw `button[3:0]` pad inputs to `clk` and filters contact bounce per channel. It produces clean debounced levels plus single-cycle press pulses, so a single physical hit scores exactly once. The scoring logic consumes `btn_press` in place of raw `button`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): consecutive stable cycles required before a level change is accepted; legal range 2 to 2^24.
- `CNT_W`, default 24: width of each per-channel stability counter; must hold `DEBOUNCE_CYCLES-1`.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `button`  input  4  raw asynchronous pad inputs; 1 = pressed after optional inversion (see Configuration).
- `btn_level`  output  4  debounced level per channel.
- `btn_press`  output  4  one-cycle pulse on each debounced 0->1 transition.
- `press_any`  output  1  OR of `btn_press`, same cycle.
- `press_idx`  output  2  index of the lowest-numbered channel pulsing this cycle; 0 when none.

## Operation
- **Synchroniser:** each channel uses a 2-flop chain `s1 -> s2`. `s2` is the sampled value. Reset value is 0 (released).
- **Per-channel FSM and counter `cnt[CNT_W-1:0]`.** States:
  - `REL`: stable released; `btn_level=0`.
  - `P_WAIT`: candidate press.
  - `PRS`: stable pressed; `btn_level=1`.
  - `R_WAIT`: candidate release.
- **Transitions:**
  - `REL`: `s2=1` -> `P_WAIT`, `cnt<=0`.
  - `P_WAIT`: `s2=0` -> `REL`, `cnt<=0`. `s2=1` with `cnt==DEBOUNCE_CYCLES-2` -> `PRS`, assert `btn_press` for that channel for the single following cycle. Otherwise `cnt<=cnt+1`.
  - `PRS`: `s2=0` -> `R_WAIT`, `cnt<=0`.
  - `R_WAIT`: `s2=1` -> `PRS`, `cnt<=0`. `s2=0` with `cnt==DEBOUNCE_CYCLES-2` -> `REL`, no pulse. Otherwise `cnt<=cnt+1`.
- `btn_level` is registered and equals 1 exactly in `PRS` and `R_WAIT`.
- `btn_press[i]` is registered and high for exactly one cycle per `REL->PRS` acceptance. It can never be high in two consecutive cycles.
- `press_idx` is a combinational priority encode of registered `btn_press`: bit 0 has the highest priority. It is valid only when `press_any=1`.
- **Simultaneous presses:** all qualifying channels pulse in the same cycle. `press_idx` reports the lowest index; the other pulses remain visible on `btn_press`.
- **Counter** never wraps. It is cleared on every state entry and saturates by construction.

## Timing
- **Reset:** all state `REL`, `cnt=0`, `s1=s2=0`, `btn_level=0`, `btn_press=0`, `press_any=0`, `press_idx=0`. Takes effect on the first edge with `reset=1`.
- **Press latency:** raw input stable high from before edge E0 gives `s2=1` after E1. `btn_level` and `btn_press` rise after edge E1+`DEBOUNCE_CYCLES`, i.e. `DEBOUNCE_CYCLES+1` cycles from the first sampling edge.
- **Release latency:** the same count. `btn_press` stays 0 on release.
- **Glitches:** a bounce shorter than `DEBOUNCE_CYCLES` cycles in `s2` produces no level change and no pulse.
- **Button held through reset:** it is treated as a new press after reset deassertion and pulses once after the full latency.
- **Reset mid-count:** the count is discarded and no pulse is issued.

## Configuration
- `BTN_ACTIVE_LOW_EN`:
  - Defined: the raw `button` inputs are inverted before `s1`, for pull-up pads where 0 = pressed. The synchroniser reset value becomes 1 at the pad side, so `s1`/`s2` still reset to logical 0 (released).
  - Undefined: inputs are used as-is (1 = pressed).

## Test plan
Bench uses `DEBOUNCE_CYCLES=4`.
- Reset held 3 cycles with `button=4'b1111` -> all outputs 0 during reset. After release, `btn_level=4'b1111` and `btn_press=4'b1111` for one cycle, 5 cycles after the first post-reset edge; `press_idx=0`.
- `button[2]` high steady -> `btn_press=4'b0100` for exactly 1 cycle, `press_idx=2`, `btn_level[2]=1` thereafter. Release -> `btn_level[2]=0` after 5 cycles, no pulse.
- `button[1]` toggling 1,1,1,0 repeatedly (bounce of 3 cycles) -> `btn_level[1]` stays 0 and `btn_press` is never asserted.
- `button[3]` and `button[1]` rise on the same edge -> `btn_press=4'b1010` in one cycle, `press_idx=1`, `press_any=1`.
- `button[0]` pressed, then `reset` pulsed 1 cycle while in `P_WAIT` with `cnt=2` -> no pulse at the original deadline. A pulse follows 5 cycles after reset release with the button still held.
- With `BTN_ACTIVE_LOW_EN` defined, `button=4'b1110` steady -> `btn_press=4'b0001` once, and `btn_level=4'b0001`.
